mmu_req_arbiter: RTL
====================

# mmu_req_arbiter

Two-requester arbiter and sequencer in front of the MMU/cache request port (`rd_req`/`wr_req` pair into the direct-mapped cache and AXI master). It shares that single port between the instruction-fetch path and the load/store path. It keeps at most one transaction outstanding, holds the downstream address, data and tag stable until completion, and routes each response back to the requester that owns it. A watchdog counter recovers from a lost completion.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: wait-state watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `mmu_clk`  in  1  clock. This is the only clock; all logic is on its rising edge.
- `i_rstn`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  instruction read request; held until `if_gnt`.
- `if_addr`  in  32  instruction address; stable while `if_req` is high.
- `if_gnt`  out  1  one-cycle grant pulse.
- `if_rsp_valid`  out  1  one-cycle instruction data valid.
- `if_rsp_data`  out  32  instruction word.
- `d_rd_req`  in  1  load request; held until `d_gnt`.
- `d_wr_req`  in  1  store request; held until `d_gnt`.
- `d_addr`  in  32  load/store address.
- `d_wdata`  in  32  store data.
- `d_func3`  in  3  load/store width code.
- `d_reg`  in  5  load destination register tag.
- `d_gnt`  out  1  one-cycle grant pulse.
- `d_rsp_valid`  out  1  one-cycle load data valid.
- `d_rsp_data`  out  32  load data.
- `d_rsp_reg`  out  5  returned register tag.
- `d_rsp_func3`  out  3  returned func3.
- `d_wr_done`  out  1  one-cycle store complete.
- `m_rd_req`  out  1  one-cycle read request to the MMU.
- `m_rd_addr`  out  32  held until completion.
- `m_rd_req_reg`  out  5  held until completion.
- `m_rd_req_func3`  out  3  held until completion.
- `m_rd_valid`  in  1  MMU read completion.
- `m_rd_data`  in  32  MMU read data.
- `m_rd_valid_reg`  in  5  MMU returned register tag.
- `m_rd_valid_func3`  in  3  MMU returned func3.
- `m_wr_req`  out  1  one-cycle write request to the MMU.
- `m_wr_addr`  out  32  held until completion.
- `m_wr_data`  out  32  held until completion.
- `m_wr_req_func3`  out  3  held until completion.
- `m_wr_done`  in  1  MMU write completion.
- `busy`  out  1  high while in any state other than IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, request present: select a winner and register its request onto the `m_*` outputs.
  - Move to RD_WAIT for reads, WR_WAIT for writes.
  - Record the owner bit (IF or D).
  - Pulse the owner's `*_gnt` and `m_rd_req`/`m_wr_req` in the same cycle.
- Instruction fetches go downstream with `m_rd_req_func3`=3'b010 and `m_rd_req_reg`=5'd0.
- Data port, `d_rd_req` and `d_wr_req` both high: the write is served first; the read remains pending.
- Priority with the macro undefined: data port over instruction port (fixed).
- RD_WAIT, `m_rd_valid`=1:
  - Copy `m_rd_data`, plus `m_rd_valid_reg` and `m_rd_valid_func3` when the owner is D, to the owner's response outputs.
  - Pulse the owner's `*_rsp_valid` the next cycle.
  - Return to IDLE.
- WR_WAIT, `m_wr_done`=1: pulse `d_wr_done` the next cycle and return to IDLE.
- Completions received in IDLE, and completions of the wrong kind for the current state, are ignored.
- Watchdog:
  - A 32-bit counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle in those states.
  - When the counter reaches `TIMEOUT_CYCLES`-1 and no completion arrives that cycle: go to IDLE, pulse `timeout_err`, emit no response.
  - If a completion and the limit occur in the same cycle, the completion wins.
- Reset: `i_rstn`=0 at a clock edge forces IDLE from any state, including mid-transaction. After reset:
  - all outputs are 0: pulses, `busy`, `timeout_err`, and all data, address and tag registers;
  - the counter is 0;
  - the round-robin pointer selects the data port.
- A completion for an aborted transaction that arrives after reset is ignored by the rule above.

## Timing
- Request seen high in IDLE at edge N: `*_gnt`, `m_*_req`, `busy` and the `m_*` payload are valid in cycle N+1.
- A requester may drop its request, or change address/data, the cycle after `*_gnt`.
- Completion sampled at edge M: the response pulse is in cycle M+1, and the FSM is in IDLE in cycle M+1.
- Earliest next grant: cycle M+2.
- Minimum turnaround per transaction is 3 cycles plus MMU latency.
- `m_*` payload is stable from the grant cycle through the completion cycle.
- Response data registers hold their values until the next response.

## Configuration
- `MMU_ARB_RR_EN`:
  - Defined: round-robin arbitration. A 1-bit last-winner pointer is updated at each grant. When both ports request, the port that did not win last is granted.
  - Undefined: fixed data-over-instruction priority and no pointer logic.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x1000 → `if_gnt` and `m_rd_req` with `m_rd_addr`=0x1000, func3=3'b010. MMU returns 0xDEADBEEF after 5 cycles → `if_rsp_valid` with data 0xDEADBEEF. `d_rsp_valid` stays 0.
- Store then load on the same port: `d_wr_req` and `d_rd_req` both high → write granted first (`m_wr_addr`/`m_wr_data` correct, `d_wr_done` after `m_wr_done`). The read is granted next, and `d_rsp_reg`/`d_rsp_func3` echo the MMU tags (e.g. reg 5'd7, func3 3'b100).
- Contention, `if_req` and `d_rd_req` held continuously:
  - Macro undefined: data port wins every arbitration.
  - `MMU_ARB_RR_EN` defined: grants alternate D, IF, D, IF.
- Watchdog: `TIMEOUT_CYCLES`=16, fetch granted, no `m_rd_valid` → `timeout_err` pulses 16 cycles after the grant, `busy` drops, no `if_rsp_valid`. A late `m_rd_valid` is then ignored.
- Reset mid-transaction: `i_rstn`=0 for one edge during RD_WAIT → next cycle all outputs are 0 and the FSM is in IDLE. A subsequent stray `m_rd_valid` produces no response, and a new request is granted normally.

Source files
------------

// File: rtl/mmu_req_arbiter.sv
// mmu_req_arbiter: shares the MMU request port between fetch and load/store, one transaction outstanding.
// Define MMU_ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch priority.
module mmu_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        mmu_clk,
    input  logic        i_rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_func3,
    input  logic [4:0]  d_reg,
    output logic        d_gnt,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [4:0]  d_rsp_reg,
    output logic [2:0]  d_rsp_func3,
    output logic        d_wr_done,
    output logic        m_rd_req,
    output logic [31:0] m_rd_addr,
    output logic [4:0]  m_rd_req_reg,
    output logic [2:0]  m_rd_req_func3,
    input  logic        m_rd_valid,
    input  logic [31:0] m_rd_data,
    input  logic [4:0]  m_rd_valid_reg,
    input  logic [2:0]  m_rd_valid_func3,
    output logic        m_wr_req,
    output logic [31:0] m_wr_addr,
    output logic [31:0] m_wr_data,
    output logic [2:0]  m_wr_req_func3,
    input  logic        m_wr_done,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state, state_nxt;
    logic        owner_d;
    logic [31:0] cnt;
    logic        d_req, win_d, win_if, go_rd, go_wr, rd_done, wr_done, wd_fire;

    assign d_req = d_rd_req | d_wr_req;
`ifdef MMU_ARB_RR_EN
    logic pref_if;
    // pref_if set means data won last, so fetch gets the next tie
    assign win_d = d_req & (!if_req | !pref_if);
    always_ff @(posedge mmu_clk)
        if (!i_rstn)
            pref_if <= 1'b0;
        else if (state == IDLE && (d_req || if_req))
            pref_if <= win_d;
`else
    assign win_d = d_req;
`endif
    assign win_if = if_req & !win_d;
    assign busy   = state != IDLE;

    always_ff @(posedge mmu_clk)
        if (!i_rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state == IDLE) ? '0 : cnt + 32'd1;
            if (state == IDLE)
                owner_d <= win_d;
        end

    always_comb begin
        state_nxt = (state == IDLE) ? (go_wr ? WR_WAIT : go_rd ? RD_WAIT : IDLE)
                  : (rd_done || wr_done || wd_fire) ? IDLE : state;
    end

    always_comb begin
        go_wr   = state == IDLE && win_d && d_wr_req;
        go_rd   = state == IDLE && (win_if || (win_d && !d_wr_req));
        rd_done = state == RD_WAIT && m_rd_valid;
        wr_done = state == WR_WAIT && m_wr_done;
        // a completion landing on the limit cycle takes precedence over the watchdog
        wd_fire = TIMEOUT_CYCLES != 0 && state != IDLE && cnt == 32'(TIMEOUT_CYCLES - 1)
                  && !rd_done && !wr_done;
    end

    always_ff @(posedge mmu_clk)
        if (!i_rstn) begin
            if_gnt         <= 1'b0;
            if_rsp_valid   <= 1'b0;
            if_rsp_data    <= '0;
            d_gnt          <= 1'b0;
            d_rsp_valid    <= 1'b0;
            d_rsp_data     <= '0;
            d_rsp_reg      <= '0;
            d_rsp_func3    <= '0;
            d_wr_done      <= 1'b0;
            m_rd_req       <= 1'b0;
            m_rd_addr      <= '0;
            m_rd_req_reg   <= '0;
            m_rd_req_func3 <= '0;
            m_wr_req       <= 1'b0;
            m_wr_addr      <= '0;
            m_wr_data      <= '0;
            m_wr_req_func3 <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if_gnt       <= state == IDLE && win_if;
            d_gnt        <= state == IDLE && win_d;
            m_rd_req     <= go_rd;
            m_wr_req     <= go_wr;
            if_rsp_valid <= rd_done && !owner_d;
            d_rsp_valid  <= rd_done && owner_d;
            d_wr_done    <= wr_done;
            timeout_err  <= wd_fire;
            if (go_rd) begin
                m_rd_addr      <= win_if ? if_addr : d_addr;
                m_rd_req_reg   <= win_if ? 5'd0 : d_reg;
                m_rd_req_func3 <= win_if ? 3'b010 : d_func3;
            end
            if (go_wr) begin
                m_wr_addr      <= d_addr;
                m_wr_data      <= d_wdata;
                m_wr_req_func3 <= d_func3;
            end
            if (rd_done && !owner_d)
                if_rsp_data <= m_rd_data;
            if (rd_done && owner_d) begin
                d_rsp_data  <= m_rd_data;
                d_rsp_reg   <= m_rd_valid_reg;
                d_rsp_func3 <= m_rd_valid_func3;
            end
        end
endmodule
